mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and one reset: clk input 1 (all state on rising edge); rst_n input 1, asynchronous, active-low.
REQ-002 The instruction port SHALL be: instr_enable in 1 (request level); instr_addr in 25 (byte address); instr_valid out 1 (one-cycle completion pulse); instr_result out 32 (fetched word).
REQ-003 The data port SHALL be: data_enable in 1; data_rw in 1 (1=write); data_oplen in 2 (00 byte .. 11 word); data_unsigned in 1; data_addr in 25; data_wdata in 32; data_valid out 1 (pulse); data_result out 32.
REQ-004 The memory port SHALL be: mem_req out 1 (level, held until done); mem_rw out 1; mem_oplen out 2; mem_unsigned out 1; mem_addr out 25; mem_wdata out 32; mem_done in 1 (one-cycle pulse); mem_rdata in 32.
REQ-005 The block SHALL have one status output: mem_timeout out 1, a one-cycle pulse on watchdog abort.

Function
REQ-006 The FSM SHALL have states IDLE, BUSY and DONE; the grant SHALL be GNT_INSTR or GNT_DATA.
REQ-007 In IDLE with at least one enable high, the block SHALL latch the winner's fields and grant, and enter BUSY next cycle with mem_req=1 and mem_* driven from the latched fields.
REQ-008 Instruction grants SHALL drive mem_rw=0, mem_oplen=11 and mem_unsigned=1.
REQ-009 In BUSY, mem_done=1 SHALL register mem_rdata into the granted port's result, deassert mem_req and enter DONE.
REQ-010 In DONE, the block SHALL pulse exactly the granted port's valid for one cycle and return to IDLE.
REQ-011 Latency SHALL be: enable sampled in IDLE at cycle N; mem_req high at N+1; mem_done at M; valid at M+1; next grant earliest at M+2.
REQ-012 A requester still holding enable in the IDLE cycle after its valid SHALL be treated as issuing a new request.
REQ-013 The result registers SHALL hold their value until the next completion for that port.
REQ-014 mem_done SHALL be ignored in IDLE and DONE.
REQ-015 The watchdog counter SHALL count from 0 in BUSY; if it reaches TIMEOUT_CYCLES (255) without mem_done, the block SHALL drop mem_req, pulse mem_timeout, load result 32'hDEADBEEF, and go to DONE (valid still pulses).
REQ-016 mem_done and the timeout in the same cycle SHALL count as done, with no timeout pulse.
REQ-017 Write completions SHALL return mem_rdata unchanged on data_result.

Reset
REQ-018 While rst_n=0, the block SHALL hold: state IDLE, mem_req 0, all valids 0, mem_timeout 0, results 0, latched fields 0, watchdog 0, round-robin pointer favouring data.
REQ-019 Reset mid-BUSY SHALL abandon the transaction with no valid pulse; the backend is reset by the same rst_n.

Configuration
REQ-020 Macro MEM_ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-021 When MEM_ARB_ROUND_ROBIN_EN is defined, on simultaneous requests the block SHALL grant the port not granted last time; a single request always wins.
REQ-022 When MEM_ARB_ROUND_ROBIN_EN is undefined, data SHALL always beat instr on simultaneous requests, and no pointer register SHALL exist.

Structure
REQ-023 Package mem_arb_pkg SHALL hold: the state enum, the grant enum, an oplen typedef (OP_BYTE/OP_HALF/OP_TRI/OP_WORD), ADDR_W=25, DATA_W=32, TIMEOUT_CYCLES=255 and TIMEOUT_DATA=32'hDEADBEEF.
REQ-024 A sub-module mem_arb_pick SHALL provide the combinational grant selection from both enables and the pointer; it is the only sub-module.

Verification
REQ-025 Single instr at addr 0x0C, backend done after 8 cycles with 0x00000013: mem_addr=0x0C and mem_rw=0 while BUSY; instr_valid one cycle after done; instr_result=0x00000013.
REQ-026 Data write at addr 0x14, wdata 0x21, oplen 11: mem_rw=1, mem_wdata=0x21, mem_oplen=11 during BUSY; data_valid one pulse; instr_valid stays 0.
REQ-027 Both enables high continuously for 4 transactions: grants D,D,D,D without the macro; D,I,D,I with MEM_ARB_ROUND_ROBIN_EN.
REQ-028 Backend never asserts done: mem_timeout and valid pulse exactly when the watchdog reaches 255; result=0xDEADBEEF; mem_req low afterwards.
REQ-029 rst_n pulsed low mid-BUSY: mem_req drops asynchronously; no valid pulse; a new request after reset completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Holds FSM/grant enums, the latched request bundle and watchdog limits.
package mem_arb_pkg;

  localparam int ADDR_W         = 25;
  localparam int DATA_W         = 32;
  localparam int TIMEOUT_CYCLES = 255;
  localparam int WD_W           = 8;

  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF;
  localparam logic [WD_W-1:0]   WD_MAX       = WD_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_e;

  typedef enum logic {
    GNT_INSTR,
    GNT_DATA
  } gnt_e;

  typedef enum logic [1:0] {
    OP_BYTE,
    OP_HALF,
    OP_TRI,
    OP_WORD
  } oplen_e;

  typedef struct packed {
    gnt_e              gnt;
    logic              rw;
    oplen_e            oplen;
    logic              uns;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between instruction and data requests.
// On contention the port named by prio_i wins; a lone request always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic instr_en_i,
  input  logic data_en_i,
  input  gnt_e prio_i,
  output logic any_o,
  output gnt_e gnt_o
);

  // pick the winner from the two enables and the priority hint
  always_comb begin
    any_o = instr_en_i | data_en_i;
    gnt_o = GNT_DATA;
    unique case (1'b1)
      (instr_en_i && data_en_i):  gnt_o = prio_i;
      (data_en_i && !instr_en_i): gnt_o = GNT_DATA;
      (instr_en_i && !data_en_i): gnt_o = GNT_INSTR;
      default:                    gnt_o = GNT_DATA;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (instr/data) arbiter onto one memory backend with a watchdog.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; otherwise data always wins.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_enable_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  output logic              instr_valid_o,
  output logic [DATA_W-1:0] instr_result_o,
  input  logic              data_enable_i,
  input  logic              data_rw_i,
  input  logic [1:0]        data_oplen_i,
  input  logic              data_unsigned_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_valid_o,
  output logic [DATA_W-1:0] data_result_o,
  output logic              mem_req_o,
  output logic              mem_rw_o,
  output logic [1:0]        mem_oplen_o,
  output logic              mem_unsigned_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_done_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              mem_timeout_o
);

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              to_q, to_d;
  logic [DATA_W-1:0] ires_q, ires_d;
  logic [DATA_W-1:0] dres_q, dres_d;

  logic any;
  gnt_e pick_gnt;
  gnt_e prio;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  gnt_e prio_q, prio_d;

  // after every grant, favour the other port next time
  always_comb begin
    prio_d = prio_q;
    if (state_q == ST_IDLE && any)
      prio_d = (pick_gnt == GNT_DATA) ? GNT_INSTR : GNT_DATA;
  end

  // round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prio_q <= GNT_DATA;
    else        prio_q <= prio_d;
  end

  assign prio = prio_q;
`else
  assign prio = GNT_DATA;
`endif

  mem_arb_pick u_pick (
    .instr_en_i (instr_enable_i),
    .data_en_i  (data_enable_i),
    .prio_i     (prio),
    .any_o      (any),
    .gnt_o      (pick_gnt)
  );

  // next-state, request latch, watchdog and result capture
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wd_d    = wd_q;
    to_d    = 1'b0;
    ires_d  = ires_q;
    dres_d  = dres_q;
    unique case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (any) begin
          state_d = ST_BUSY;
          if (pick_gnt == GNT_DATA) begin
            req_d.gnt   = GNT_DATA;
            req_d.rw    = data_rw_i;
            req_d.oplen = oplen_e'(data_oplen_i);
            req_d.uns   = data_unsigned_i;
            req_d.addr  = data_addr_i;
            req_d.wdata = data_wdata_i;
          end else begin
            req_d.gnt   = GNT_INSTR;
            req_d.rw    = 1'b0;
            req_d.oplen = OP_WORD;
            req_d.uns   = 1'b1;
            req_d.addr  = instr_addr_i;
            req_d.wdata = '0;
          end
        end
      end
      ST_BUSY: begin
        if (mem_done_i) begin
          state_d = ST_DONE;
          if (req_q.gnt == GNT_DATA) dres_d = mem_rdata_i;
          else                       ires_d = mem_rdata_i;
        end else if (wd_q == WD_MAX) begin
          state_d = ST_DONE;
          to_d    = 1'b1;
          if (req_q.gnt == GNT_DATA) dres_d = TIMEOUT_DATA;
          else                       ires_d = TIMEOUT_DATA;
        end else begin
          wd_d = wd_q + 8'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
      ires_q  <= '0;
      dres_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      ires_q  <= ires_d;
      dres_q  <= dres_d;
    end
  end

  assign mem_req_o      = (state_q == ST_BUSY);
  assign mem_rw_o       = req_q.rw;
  assign mem_oplen_o    = req_q.oplen;
  assign mem_unsigned_o = req_q.uns;
  assign mem_addr_o     = req_q.addr;
  assign mem_wdata_o    = req_q.wdata;
  assign mem_timeout_o  = to_q;

  assign instr_valid_o  = (state_q == ST_DONE) && (req_q.gnt == GNT_INSTR);
  assign data_valid_o   = (state_q == ST_DONE) && (req_q.gnt == GNT_DATA);
  assign instr_result_o = ires_q;
  assign data_result_o  = dres_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: backend model, grant order,
// watchdog abort, done/timeout tie and asynchronous reset mid-transaction.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              instr_enable_i = 1'b0;
  logic [ADDR_W-1:0] instr_addr_i = '0;
  logic              instr_valid_o;
  logic [DATA_W-1:0] instr_result_o;
  logic              data_enable_i = 1'b0;
  logic              data_rw_i = 1'b0;
  logic [1:0]        data_oplen_i = 2'b00;
  logic              data_unsigned_i = 1'b0;
  logic [ADDR_W-1:0] data_addr_i = '0;
  logic [DATA_W-1:0] data_wdata_i = '0;
  logic              data_valid_o;
  logic [DATA_W-1:0] data_result_o;
  logic              mem_req_o;
  logic              mem_rw_o;
  logic [1:0]        mem_oplen_o;
  logic              mem_unsigned_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_done_i = 1'b0;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              mem_timeout_o;

  mem_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .instr_enable_i  (instr_enable_i),
    .instr_addr_i    (instr_addr_i),
    .instr_valid_o   (instr_valid_o),
    .instr_result_o  (instr_result_o),
    .data_enable_i   (data_enable_i),
    .data_rw_i       (data_rw_i),
    .data_oplen_i    (data_oplen_i),
    .data_unsigned_i (data_unsigned_i),
    .data_addr_i     (data_addr_i),
    .data_wdata_i    (data_wdata_i),
    .data_valid_o    (data_valid_o),
    .data_result_o   (data_result_o),
    .mem_req_o       (mem_req_o),
    .mem_rw_o        (mem_rw_o),
    .mem_oplen_o     (mem_oplen_o),
    .mem_unsigned_o  (mem_unsigned_o),
    .mem_addr_o      (mem_addr_o),
    .mem_wdata_o     (mem_wdata_o),
    .mem_done_i      (mem_done_i),
    .mem_rdata_i     (mem_rdata_i),
    .mem_timeout_o   (mem_timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_data;
    logic [31:0] res;
  } sb_t;

  sb_t sbq[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(logic d, logic [31:0] r);
    sb_t e;
    e.is_data = d;
    e.res     = r;
    sbq.push_back(e);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!mem_req_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_seen", mem_req_o, 1);
  endtask

  task automatic finish(logic [31:0] rd, logic d, int dly);
    repeat (dly) @(posedge clk);
    #1;
    mem_done_i  = 1'b1;
    mem_rdata_i = rd;
    @(posedge clk);
    #1;
    mem_done_i = 1'b0;
    chk("req_drop", mem_req_o, 0);
    @(negedge clk);
    chk("valid_at", {data_valid_o, instr_valid_o}, d ? 2 : 1);
    chk("no_tmo", mem_timeout_o, 0);
    @(negedge clk);
    chk("valid_pulse", {data_valid_o, instr_valid_o}, 0);
  endtask

  // completion monitor: every valid pulse pops one expected result
  always @(negedge clk) begin
    if (rst_n && (instr_valid_o || data_valid_o)) begin
      chk("v_excl", instr_valid_o & data_valid_o, 0);
      if (sbq.size() == 0) begin
        chk("v_unexp", instr_valid_o | data_valid_o, 0);
      end else begin
        sb_t e;
        e = sbq.pop_front();
        chk("v_port", data_valid_o, e.is_data);
        chk("v_res", data_valid_o ? data_result_o : instr_result_o, e.res);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    logic exp_d;
    logic got_d;
    logic [31:0] rd;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", mem_req_o, 0);
    chk("rst_ivalid", instr_valid_o, 0);
    chk("rst_dvalid", data_valid_o, 0);
    chk("rst_tmo", mem_timeout_o, 0);
    chk("rst_ires", instr_result_o, 0);
    chk("rst_dres", data_result_o, 0);
    chk("rst_addr", mem_addr_o, 0);
    rst_n = 1'b1;

    // stray done while idle
    @(posedge clk);
    #1;
    mem_done_i  = 1'b1;
    mem_rdata_i = 32'hBAD0BAD0;
    @(posedge clk);
    #1;
    mem_done_i = 1'b0;
    @(negedge clk);
    chk("idle_done_req", mem_req_o, 0);
    chk("idle_done_ires", instr_result_o, 0);
    chk("idle_done_dres", data_result_o, 0);

    // single instruction fetch
    instr_addr_i   = 25'h0C;
    instr_enable_i = 1'b1;
    push(1'b0, 32'h00000013);
    wait_req();
    instr_enable_i = 1'b0;
    chk("i_addr", mem_addr_o, 25'h0C);
    chk("i_rw", mem_rw_o, 0);
    chk("i_oplen", mem_oplen_o, 2'b11);
    chk("i_uns", mem_unsigned_o, 1);
    finish(32'h00000013, 1'b0, 8);

    // data write
    data_rw_i     = 1'b1;
    data_oplen_i  = 2'b11;
    data_addr_i   = 25'h14;
    data_wdata_i  = 32'h21;
    data_enable_i = 1'b1;
    push(1'b1, 32'hCAFE0001);
    wait_req();
    data_enable_i = 1'b0;
    chk("w_rw", mem_rw_o, 1);
    chk("w_wdata", mem_wdata_o, 32'h21);
    chk("w_oplen", mem_oplen_o, 2'b11);
    chk("w_addr", mem_addr_o, 25'h14);
    finish(32'hCAFE0001, 1'b1, 3);
    chk("hold_ires", instr_result_o, 32'h13);

    // reset restores the data-favouring pointer
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // continuous contention
    instr_addr_i    = 25'h100;
    data_addr_i     = 25'h200;
    data_rw_i       = 1'b0;
    data_oplen_i    = 2'b01;
    data_unsigned_i = 1'b0;
    instr_enable_i  = 1'b1;
    data_enable_i   = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      rd = 32'h1000 + k;
      push(exp_d, rd);
      wait_req();
      if (k == 3) begin
        instr_enable_i = 1'b0;
        data_enable_i  = 1'b0;
      end
      got_d = (mem_addr_o == 25'h200);
      chk("arb_gnt", got_d, exp_d);
      chk("arb_oplen", mem_oplen_o, exp_d ? 2'b01 : 2'b11);
      chk("arb_uns", mem_unsigned_o, exp_d ? 0 : 1);
      finish(rd, exp_d, 1);
    end

    // watchdog abort
    instr_addr_i   = 25'h30;
    instr_enable_i = 1'b1;
    push(1'b0, TIMEOUT_DATA);
    wait_req();
    instr_enable_i = 1'b0;
    n = 1;
    do begin
      @(negedge clk);
      if (mem_req_o) n++;
    end while (mem_req_o && n < 400);
    chk("wd_cycles", n, 256);
    chk("tmo_pulse", mem_timeout_o, 1);
    chk("tmo_valid", instr_valid_o, 1);
    @(negedge clk);
    chk("tmo_clear", mem_timeout_o, 0);
    chk("tmo_req_low", mem_req_o, 0);

    // done on the same cycle the watchdog expires
    instr_enable_i = 1'b1;
    push(1'b0, 32'h77);
    wait_req();
    instr_enable_i = 1'b0;
    finish(32'h77, 1'b0, 255);

    // reset in the middle of a transaction
    data_addr_i   = 25'h44;
    data_enable_i = 1'b1;
    wait_req();
    data_enable_i = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_req_async", mem_req_o, 0);
    chk("rst_ires_clr", instr_result_o, 0);
    repeat (2) @(negedge clk);
    chk("rst_no_valid", {data_valid_o, instr_valid_o}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", mem_req_o, 0);

    instr_addr_i   = 25'h40;
    instr_enable_i = 1'b1;
    push(1'b0, 32'h55);
    wait_req();
    instr_enable_i = 1'b0;
    chk("post_rst_addr", mem_addr_o, 25'h40);
    finish(32'h55, 1'b0, 2);

    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
